// File: rtl/histo_equalizer.sv
// rtl/histo_equalizer.sv - CDF-driven histogram equalisation LUT builder and inline pixel remapper
// Optional double-buffered LUT selected by HISTO_EQ_DBUF_EN.
module histo_equalizer #(
  parameter int CNT_W  = 20,
  parameter int RD_LAT = 1
) (
  input  logic             iPclk,
  input  logic             iRst,
  input  logic             Fval,
  input  logic             Dval,
  input  logic [7:0]       Grey,
  input  logic             iStart,
  output logic [7:0]       oCdf_Rd_Addr,
  input  logic [CNT_W-1:0] iCdf_Q,
  output logic [7:0]       oGrey,
  output logic             oDval,
  output logic             oBusy,
  output logic             oLut_Valid,
  output logic [1:0]       oState
);

  localparam int       NUM_W   = CNT_W + 8;
  localparam bit [8:0] LD_LAST = 9'(255 + RD_LAT);
  localparam bit [3:0] PH_WR   = 4'd10;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_CALC = 2'd2, S_READY = 2'd3} state_t;

  state_t           state, state_nxt;
  logic             fval_d;
  logic             fval_rise;
  logic [7:0]       addr;
  logic [8:0]       ld_cnt;
  logic [7:0]       cap_idx;
  logic             cap_en;
  logic [7:0]       g_idx;
  logic [3:0]       phase;
  logic [CNT_W-1:0] cdf_min;
  logic             min_found;
  logic [CNT_W-1:0] total;
  logic [CNT_W-1:0] cdf_buf [0:255];
  logic [CNT_W-1:0] cdf_rd;
  logic [NUM_W-1:0] num_c;
  logic [CNT_W-1:0] den_c;
  logic [7:0]       num_lo;
  logic [CNT_W-1:0] den;
  logic [CNT_W-1:0] rem;
  logic [CNT_W:0]   trial;
  logic [2:0]       bit_idx;
  logic [7:0]       quo;
  logic             ovf;
  logic             lut_valid;
  logic             lut_we;
  logic [7:0]       lut_wdata;
  logic [7:0]       lut_rd;
  logic [7:0]       grey_d1;
  logic             dval_d1;
  logic             sel_d1;

`ifdef HISTO_EQ_DBUF_EN
  localparam int LUT_DEPTH = 512;
  logic act_sel;
  logic swap_pend;
  logic [8:0] lut_wa, lut_ra;
  assign lut_wa = {~act_sel, g_idx};
  assign lut_ra = {act_sel, Grey};
`else
  localparam int LUT_DEPTH = 256;
  logic [7:0] lut_wa, lut_ra;
  assign lut_wa = g_idx;
  assign lut_ra = Grey;
`endif

  logic [7:0] lut [0:LUT_DEPTH-1];

  assign fval_rise = Fval & ~fval_d;
  assign cap_en    = (state == S_LOAD) && (ld_cnt >= 9'(RD_LAT));
  assign cap_idx   = 8'(ld_cnt - 9'(RD_LAT));

  always_ff @(posedge iPclk) begin
    if (iRst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_READY: if (iStart && !Fval) state_nxt = S_LOAD;
      S_LOAD: begin
        if (fval_rise)              state_nxt = S_IDLE;
        else if (ld_cnt == LD_LAST) state_nxt = S_CALC;
      end
      S_CALC: begin
        if (fval_rise)                               state_nxt = S_IDLE;
        else if (phase == PH_WR && g_idx == 8'hff)   state_nxt = S_READY;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    oBusy  = (state == S_LOAD) || (state == S_CALC);
    oState = state;
  end

  // Scale numerator by 255; a word below cdf_min contributes nothing.
  always_comb begin
    num_c = '0;
    if (cdf_rd >= cdf_min) num_c = NUM_W'(cdf_rd - cdf_min) * NUM_W'(255);
    den_c = (total > cdf_min) ? (total - cdf_min) : '0;
  end

  assign bit_idx   = 3'(4'd9 - phase);
  assign trial     = {rem, num_lo[bit_idx]};
  assign lut_we    = (state == S_CALC) && (phase == PH_WR);
  assign lut_wdata = (den == '0) ? g_idx : (ovf ? 8'hff : quo);

  always_ff @(posedge iPclk) begin
    if (cap_en) cdf_buf[cap_idx] <= iCdf_Q;
    cdf_rd <= cdf_buf[g_idx];
  end

  always_ff @(posedge iPclk) begin
    if (lut_we) lut[lut_wa] <= lut_wdata;
    lut_rd <= lut[lut_ra];
  end

  always_ff @(posedge iPclk) begin
    if (iRst) begin
      fval_d    <= 1'b0;
      addr      <= '0;
      ld_cnt    <= '0;
      g_idx     <= '0;
      phase     <= '0;
      cdf_min   <= '0;
      min_found <= 1'b0;
      total     <= '0;
      num_lo    <= '0;
      den       <= '0;
      rem       <= '0;
      quo       <= '0;
      ovf       <= 1'b0;
      lut_valid <= 1'b0;
`ifdef HISTO_EQ_DBUF_EN
      act_sel   <= 1'b0;
      swap_pend <= 1'b0;
`endif
    end else begin
      fval_d <= Fval;
      case (state)
        S_IDLE, S_READY: begin
          if (state_nxt == S_LOAD) begin
            addr      <= '0;
            ld_cnt    <= '0;
            g_idx     <= '0;
            phase     <= '0;
            cdf_min   <= '0;
            min_found <= 1'b0;
`ifdef HISTO_EQ_DBUF_EN
            swap_pend <= 1'b0;
`else
            lut_valid <= 1'b0;
`endif
          end
`ifdef HISTO_EQ_DBUF_EN
          else if (state == S_READY && swap_pend && fval_rise) begin
            act_sel   <= ~act_sel;
            swap_pend <= 1'b0;
            lut_valid <= 1'b1;
          end
`endif
        end
        S_LOAD: begin
          if (fval_rise) begin
`ifndef HISTO_EQ_DBUF_EN
            lut_valid <= 1'b0;
`endif
          end else begin
            if (addr != 8'hff) addr <= addr + 8'd1;
            ld_cnt <= ld_cnt + 9'd1;
            if (cap_en) begin
              if (!min_found && iCdf_Q != '0) begin
                cdf_min   <= iCdf_Q;
                min_found <= 1'b1;
              end
              if (cap_idx == 8'hff) total <= iCdf_Q;
            end
          end
        end
        S_CALC: begin
          if (fval_rise) begin
`ifndef HISTO_EQ_DBUF_EN
            lut_valid <= 1'b0;
`endif
          end else begin
            phase <= (phase == PH_WR) ? 4'd0 : phase + 4'd1;
            if (phase == 4'd1) begin
              num_lo <= num_c[7:0];
              den    <= den_c;
              rem    <= num_c[NUM_W-1:8];
              ovf    <= (num_c[NUM_W-1:8] >= den_c);
              quo    <= '0;
            end else if (phase >= 4'd2 && phase <= 4'd9) begin
              // One restoring step per cycle, MSB first.
              if (trial >= {1'b0, den}) begin
                rem          <= CNT_W'(trial - {1'b0, den});
                quo[bit_idx] <= 1'b1;
              end else begin
                rem <= trial[CNT_W-1:0];
              end
            end else if (phase == PH_WR) begin
              g_idx <= g_idx + 8'd1;
              if (g_idx == 8'hff) begin
`ifdef HISTO_EQ_DBUF_EN
                swap_pend <= 1'b1;
`else
                lut_valid <= 1'b1;
`endif
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge iPclk) begin
    if (iRst) begin
      grey_d1 <= '0;
      dval_d1 <= 1'b0;
      sel_d1  <= 1'b0;
      oGrey   <= '0;
      oDval   <= 1'b0;
    end else begin
      grey_d1 <= Grey;
      dval_d1 <= Dval;
      sel_d1  <= lut_valid;
      oDval   <= dval_d1;
      oGrey   <= dval_d1 ? (sel_d1 ? lut_rd : grey_d1) : 8'd0;
    end
  end

  assign oCdf_Rd_Addr = addr;
  assign oLut_Valid   = lut_valid;

endmodule

// File: tb/tb_histo_equalizer.sv
// tb/tb_histo_equalizer.sv - randomized self-checking bench for histo_equalizer
// Honours HISTO_EQ_DBUF_EN when the design is built with it.
module tb_histo_equalizer;

  localparam int CNT_W = 20;

  logic             iPclk = 1'b0;
  logic             iRst, Fval, Dval, iStart;
  logic [7:0]       Grey;
  logic [7:0]       oCdf_Rd_Addr;
  logic [CNT_W-1:0] iCdf_Q;
  logic [7:0]       oGrey;
  logic             oDval, oBusy, oLut_Valid;
  logic [1:0]       oState;

  histo_equalizer #(.CNT_W(CNT_W), .RD_LAT(1)) dut (
    .iPclk(iPclk), .iRst(iRst), .Fval(Fval), .Dval(Dval), .Grey(Grey),
    .iStart(iStart), .oCdf_Rd_Addr(oCdf_Rd_Addr), .iCdf_Q(iCdf_Q),
    .oGrey(oGrey), .oDval(oDval), .oBusy(oBusy), .oLut_Valid(oLut_Valid),
    .oState(oState)
  );

  always #5 iPclk = ~iPclk;

  logic [CNT_W-1:0] cdf_mem [0:255];
  always @(posedge iPclk) iCdf_Q <= cdf_mem[oCdf_Rd_Addr];

  int n_vec = 0;
  int n_bad = 0;
  int m_active [0:255];
  int m_new    [0:255];
  bit m_valid  = 1'b0;
  logic [7:0] pg [0:63];
  bit         pd [0:63];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Equalisation formula evaluated directly with wide integer arithmetic.
  function automatic void model_lut();
    longint mn = 0, tot, den, c, q;
    bit found = 1'b0;
    for (int g = 0; g < 256; g++)
      if (!found && cdf_mem[g] != 0) begin mn = cdf_mem[g]; found = 1'b1; end
    tot = cdf_mem[255];
    den = tot - mn;
    for (int g = 0; g < 256; g++) begin
      c = cdf_mem[g];
      if (den <= 0) m_new[g] = g;
      else begin
        q = (c < mn) ? 0 : ((c - mn) * 255) / den;
        m_new[g] = (q > 255) ? 255 : int'(q);
      end
    end
  endfunction

  task automatic rand_cdf();
    int acc = 0;
    int z = $urandom_range(0, 120);
    for (int g = 0; g < 256; g++) begin
      if (g >= z) acc += $urandom_range(0, 40);
      cdf_mem[g] = CNT_W'(acc);
    end
  endtask

  task automatic rand_pix(input int first, input int last);
    for (int i = first; i < last; i++) begin
      pg[i] = 8'($urandom_range(0, 255));
      pd[i] = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic run_pixels(input string tag, input int n);
    int eg[$];
    bit ed[$];
    for (int i = 0; i < n + 2; i++) begin
      @(negedge iPclk);
      if (i >= 2) begin
        check({tag, "_grey"}, oGrey, eg.pop_front());
        check({tag, "_dval"}, oDval, ed.pop_front());
      end
      if (i < n) begin
        Dval = pd[i];
        Grey = pg[i];
        eg.push_back(pd[i] ? (m_valid ? m_active[pg[i]] : int'(pg[i])) : 0);
        ed.push_back(pd[i]);
      end else begin
        Dval = 1'b0;
        Grey = 8'd0;
      end
    end
  endtask

  // Runs one LOAD+CALC; leaves Fval high (frame running) afterwards.
  task automatic run_eq(input string tag, input int restart_at, input int abort_at, input bit chk_addr);
    int lc = 0, cc = 0;
    bit done = 1'b0, aborted = 1'b0;
    model_lut();
    @(negedge iPclk);
    Fval   = 1'b0;
    iStart = 1'b1;
    for (int t = 0; t < 4000 && !done; t++) begin
      @(negedge iPclk);
      iStart = 1'b0;
      if (t == 0) begin
        check({tag, "_enter_load"}, oState, 1);
        check({tag, "_busy"}, oBusy, 1);
`ifndef HISTO_EQ_DBUF_EN
        m_valid = 1'b0;
`endif
        check({tag, "_lutv_load"}, oLut_Valid, m_valid);
      end
      if (oState == 2'd3) done = 1'b1;
      else begin
        if (oState == 2'd1) begin
          if (chk_addr) check({tag, "_addr"}, oCdf_Rd_Addr, (lc > 255) ? 255 : lc);
          lc++;
          if (lc == restart_at) iStart = 1'b1;
        end else if (oState == 2'd2) begin
          cc++;
          if (cc == abort_at) begin
            Fval    = 1'b1;
            aborted = 1'b1;
            done    = 1'b1;
          end
        end
      end
    end
    if (!done) check({tag, "_timeout"}, 0, 1);
    else if (aborted) begin
      @(negedge iPclk);
`ifndef HISTO_EQ_DBUF_EN
      m_valid = 1'b0;
`endif
      check({tag, "_abort_state"}, oState, 0);
      check({tag, "_abort_busy"}, oBusy, 0);
      check({tag, "_abort_lutv"}, oLut_Valid, m_valid);
    end else begin
      check({tag, "_load_cycles"}, lc, 257);
      check({tag, "_total_cycles"}, lc + cc, 3073);
      check({tag, "_ready_busy"}, oBusy, 0);
`ifdef HISTO_EQ_DBUF_EN
      check({tag, "_lutv_ready"}, oLut_Valid, m_valid);
`else
      check({tag, "_lutv_ready"}, oLut_Valid, 1);
`endif
      Fval = 1'b1;
      @(negedge iPclk);
      for (int g = 0; g < 256; g++) m_active[g] = m_new[g];
      m_valid = 1'b1;
      check({tag, "_lutv_frame"}, oLut_Valid, 1);
      check({tag, "_ready_state"}, oState, 3);
    end
  endtask

  initial begin
    iRst = 1'b1; Fval = 1'b0; Dval = 1'b0; iStart = 1'b0; Grey = 8'd0;
    for (int g = 0; g < 256; g++) cdf_mem[g] = '0;
    repeat (3) @(negedge iPclk);
    check("rst_state", oState, 0);
    check("rst_busy", oBusy, 0);
    check("rst_lutv", oLut_Valid, 0);
    check("rst_addr", oCdf_Rd_Addr, 0);
    check("rst_grey", oGrey, 0);
    check("rst_dval", oDval, 0);
    iRst = 1'b0;

    pg[0] = 8'h40; pd[0] = 1'b1;
    rand_pix(1, 12);
    run_pixels("ident", 12);

    for (int g = 0; g < 256; g++) cdf_mem[g] = CNT_W'((g + 1) * 4);
    run_eq("lin", -1, -1, 1'b1);
    pg[0] = 8'd0; pg[1] = 8'd77; pg[2] = 8'd255;
    pd[0] = 1'b1; pd[1] = 1'b1; pd[2] = 1'b1;
    rand_pix(3, 20);
    run_pixels("lin", 20);

    for (int g = 0; g < 256; g++)
      cdf_mem[g] = (g < 100) ? '0 : (g < 150) ? CNT_W'((g - 99) * 10) : CNT_W'(500);
    run_eq("ramp", 100, -1, 1'b1);
    pg[0] = 8'd100; pg[1] = 8'd124; pg[2] = 8'd149; pg[3] = 8'd200;
    for (int i = 0; i < 4; i++) pd[i] = 1'b1;
    rand_pix(4, 20);
    run_pixels("ramp", 20);

    for (int g = 0; g < 256; g++) cdf_mem[g] = (g < 50) ? '0 : CNT_W'(1000);
    run_eq("flat", -1, -1, 1'b0);
    pg[0] = 8'd50; pg[1] = 8'd200; pd[0] = 1'b1; pd[1] = 1'b1;
    rand_pix(2, 16);
    run_pixels("flat", 16);

    rand_cdf();
    run_eq("rand", -1, -1, 1'b0);
    rand_pix(0, 64);
    run_pixels("rand", 64);

    rand_cdf();
    run_eq("abort", -1, 1000, 1'b0);
    rand_pix(0, 32);
    run_pixels("abort", 32);
    Fval = 1'b0;
    repeat (2) @(negedge iPclk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
